// File: rtl/iterative_left_shifter_if.sv
// Request/result bundle for the iterative left shifter: operand, shift amount,
// start pulse in one direction; result, busy and completion strobe in the other.
interface iterative_left_shifter_if;
    logic        start;
    logic [31:0] in;
    logic [4:0]  shamt;
    logic [31:0] out;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output in,
        output shamt,
        input  out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  in,
        input  shamt,
        output out,
        output busy,
        output done
    );
endinterface

// File: rtl/iterative_left_shifter.sv
// Multi-cycle 32-bit logical left shifter: consumes the shift amount two bits
// per clock (one on an odd final step), so no wide barrel mux is needed.
module iterative_left_shifter (
    input  logic                     clock,
    input  logic                     reset,
    iterative_left_shifter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] acc_r;
    logic [31:0] acc_s;
    logic [4:0]  rem_r;
    logic [4:0]  rem_s;
    logic [31:0] out_r;
    logic [31:0] out_s;
    logic        busy_r;
    logic        done_r;

    // Next-state, accumulator, remaining-count and result selection
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        rem_s   = rem_r;
        out_s   = out_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    acc_s = bus.in;
                    if (bus.shamt == 5'd0) begin
                        out_s   = bus.in;
                        state_s = DONE;
                    end else begin
                        rem_s   = bus.shamt;
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (rem_r >= 5'd2) begin
                    acc_s = {acc_r[29:0], 2'b00};
                    rem_s = rem_r - 5'd2;
                end else begin
                    acc_s = {acc_r[30:0], 1'b0};
                    rem_s = 5'd0;
                end
                // Result is published on the very edge the count runs out
                if (rem_s == 5'd0) begin
                    out_s   = acc_s;
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            acc_r   <= 32'd0;
            rem_r   <= 5'd0;
            out_r   <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            rem_r   <= rem_s;
            out_r   <= out_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    assign bus.out  = out_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_iterative_left_shifter.sv
// Randomized self-checking bench for iterative_left_shifter against a plain
// arithmetic model (result = in << shamt, latency = ceil(shamt/2) + 1).
module tb_iterative_left_shifter;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [31:0] model_out;

    iterative_left_shifter_if bus ();

    iterative_left_shifter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation: drive start for a single edge, then watch until done
    task automatic do_op(input logic [31:0] a, input logic [4:0] s, input bit disturb);
        int          edges;
        int          busy_cycles;
        int          exp_lat;
        logic [31:0] exp_out;
        exp_out = a << s;
        exp_lat = (int'(s) + 1) / 2 + 1;
        @(negedge clock);
        bus.start = 1'b1;
        bus.in    = a;
        bus.shamt = s;
        @(posedge clock);
        #1;
        edges       = 1;
        busy_cycles = 0;
        bus.start   = disturb;
        if (disturb) begin
            bus.in    = $urandom();
            bus.shamt = 5'($urandom());
        end
        while (!bus.done && edges < 40) begin
            if (bus.busy) busy_cycles++;
            check_eq("hold_out", bus.out, model_out);
            @(posedge clock);
            #1;
            edges++;
            if (disturb) begin
                bus.in    = $urandom();
                bus.shamt = 5'($urandom());
            end
        end
        if (bus.busy) busy_cycles++;
        bus.start = 1'b0;
        check_eq("latency", 32'(edges), 32'(exp_lat));
        check_eq("result", bus.out, exp_out);
        check_eq("busy_cycles", 32'(busy_cycles), 32'(exp_lat));
        model_out = exp_out;
        @(posedge clock);
        #1;
        check_eq("done_once", 32'(bus.done), 32'd0);
        check_eq("idle_busy", 32'(bus.busy), 32'd0);
        check_eq("out_held", bus.out, model_out);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        model_out = 32'd0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.in    = 32'd0;
        bus.shamt = 5'd0;
        #1;
        check_eq("rst_out", bus.out, 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        do_op(32'h0000_0001, 5'd31, 1'b0);
        do_op(32'hDEAD_BEEF, 5'd0, 1'b0);
        do_op(32'h0000_000F, 5'd5, 1'b0);
        do_op(32'h0000_0003, 5'd4, 1'b1);
        do_op(32'hFFFF_FFFF, 5'd1, 1'b0);

        // Reset in the middle of a long shift
        @(negedge clock);
        bus.start = 1'b1;
        bus.in    = 32'h1234_5678;
        bus.shamt = 5'd20;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_eq("midrst_out", bus.out, 32'd0);
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        check_eq("midrst_done", 32'(bus.done), 32'd0);
        model_out = 32'd0;
        @(negedge clock);
        reset = 1'b0;
        do_op(32'h0000_0001, 5'd1, 1'b0);

        // Start held high: accepted only from IDLE, one result every 3 cycles
        @(negedge clock);
        bus.start = 1'b1;
        bus.in    = 32'hFFFF_FFFF;
        bus.shamt = 5'd2;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clock);
            #1;
            check_eq("held_done", 32'(bus.done), ((k % 3) == 2) ? 32'd1 : 32'd0);
            check_eq("held_busy", 32'(bus.busy), ((k % 3) != 0) ? 32'd1 : 32'd0);
            if (k >= 2) check_eq("held_out", bus.out, 32'hFFFF_FFFC);
        end
        bus.start = 1'b0;
        model_out = 32'hFFFF_FFFC;
        @(posedge clock);
        #1;

        for (int n = 0; n < 30; n++) begin
            do_op($urandom(), 5'($urandom()), 1'($urandom()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
